fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core. It holds the program counter, issues in-order requests to instruction memory, and buffers returned instructions with their PCs for decode. It consumes the branch stage's `pc_update_control`, `pc_update_val` and `ignore_curr_inst` to redirect the PC and discard wrong-path instructions.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, {pc,inst} buffer for decode.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-redirect flag.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        pc_update_control,
    input  logic [31:0] pc_update_val,
    input  logic        ignore_curr_inst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        misaligned_err
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] r_rq_head;
    logic [PW-1:0] r_rq_tail;

    logic [31:0] r_buf_pc   [BUF_DEPTH];
    logic [31:0] r_buf_data [BUF_DEPTH];
    logic [31:0] r_rq_pc    [BUF_DEPTH];

    logic [CW:0] w_credit;
    logic        w_req_fire;
    logic        w_rsp_drop;
    logic        w_push;
    logic        w_pop;

    // Credits cover both in-flight requests and buffered entries, so a
    // response always finds a free buffer slot.
    assign w_credit       = {1'b0, r_outst} + {1'b0, r_count};
    assign imem_req_valid = !i_rst && !pc_update_control
                            && (w_credit < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = r_pc;

    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp_drop = imem_rsp_valid && (r_drop != '0);
    assign w_push     = !i_rst && imem_rsp_valid && (r_drop == '0)
                        && !pc_update_control;

    assign inst_valid = (r_count != '0);
    assign w_pop      = inst_valid && (inst_ready || ignore_curr_inst)
                        && !pc_update_control;
    assign inst_pc    = inst_valid ? r_buf_pc[r_head]   : 32'h0;
    assign inst_data  = inst_valid ? r_buf_data[r_head] : 32'h0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc      <= RESET_PC;
            r_outst   <= '0;
            r_drop    <= '0;
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_rq_head <= '0;
            r_rq_tail <= '0;
        end else begin
            r_outst <= r_outst + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (w_req_fire)
                r_rq_tail <= r_rq_tail + 1'b1;
            if (imem_rsp_valid)
                r_rq_head <= r_rq_head + 1'b1;
            if (pc_update_control) begin
                r_pc    <= {pc_update_val[31:2], 2'b00};
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                // Everything still in flight after this edge is wrong-path.
                r_drop  <= r_outst - CW'(imem_rsp_valid);
            end else begin
                if (w_req_fire)
                    r_pc <= r_pc + 32'd4;
                if (w_rsp_drop)
                    r_drop <= r_drop - CW'(1);
                if (w_push)
                    r_tail <= r_tail + 1'b1;
                if (w_pop)
                    r_head <= r_head + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_req_fire)
            r_rq_pc[r_rq_tail] <= r_pc;
        if (w_push) begin
            r_buf_pc[r_tail]   <= r_rq_pc[r_rq_head];
            r_buf_data[r_tail] <= imem_rsp_data;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_misalign <= 1'b0;
        else if (pc_update_control && (pc_update_val[1:0] != 2'b00))
            r_misalign <= 1'b1;
    end

    assign misaligned_err = r_misalign;
`else
    logic w_unused_low;

    assign w_unused_low   = ^pc_update_val[1:0];
    assign misaligned_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (RESET_PC=0x100, BUF_DEPTH=2) with a
// latency-1/2 in-order memory model returning ~addr as instruction data.
module tb_fetch_unit;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        pc_update_control;
    logic [31:0] pc_update_val;
    logic        ignore_curr_inst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        misaligned_err;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;

    logic        d1_v, d2_v;
    logic [31:0] d1_a, d2_a;

    fetch_unit #(
        .RESET_PC (32'h100),
        .BUF_DEPTH(2)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .pc_update_control(pc_update_control),
        .pc_update_val    (pc_update_val),
        .ignore_curr_inst (ignore_curr_inst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_pc          (inst_pc),
        .inst_data        (inst_data),
        .misaligned_err   (misaligned_err)
    );

    always #5 i_clk = ~i_clk;

    // Memory model, reset together with the DUT.
    always @(posedge i_clk) begin
        if (i_rst) begin
            d1_v <= 1'b0;
            d2_v <= 1'b0;
            d1_a <= 32'h0;
            d2_a <= 32'h0;
        end else begin
            d1_v <= imem_req_valid && imem_req_ready;
            d1_a <= imem_req_addr;
            d2_v <= d1_v;
            d2_a <= d1_a;
        end
    end

    assign imem_rsp_valid = (lat == 2) ? d2_v : d1_v;
    assign imem_rsp_data  = (lat == 2) ? ~d2_a : ~d1_a;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic rdy);
        i_rst             = 1'b1;
        pc_update_control = 1'b0;
        pc_update_val     = 32'h0;
        ignore_curr_inst  = 1'b0;
        inst_ready        = rdy;
        imem_req_ready    = 1'b1;
        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h100);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_misalign", 32'(misaligned_err), 32'h0);
        i_rst = 1'b0;
        #1;
    endtask

    logic [31:0] exp_req;
    logic [31:0] exp_inst;
    int          got_n;
    logic        exp_mis;

    initial begin
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        // Reset and in-order stream
        lat = 1;
        do_reset(1'b1);
        chk("first_req_valid", 32'(imem_req_valid), 32'h1);
        chk("first_req_addr", imem_req_addr, 32'h100);
        exp_req  = 32'h100;
        exp_inst = 32'h100;
        got_n    = 0;
        for (int i = 0; i < 15; i++) begin
            if (imem_req_valid && imem_req_ready) begin
                chk("stream_req_addr", imem_req_addr, exp_req);
                exp_req = exp_req + 32'd4;
            end
            if (inst_valid && inst_ready) begin
                chk("stream_inst_pc", inst_pc, exp_inst);
                chk("stream_inst_data", inst_data, ~exp_inst);
                exp_inst = exp_inst + 32'd4;
                got_n++;
            end
            tick();
        end
        chk("stream_count_ge8", 32'(got_n >= 8), 32'h1);

        // Back-pressure: two entries held, no new requests
        do_reset(1'b0);
        tick();
        chk("bp_c1_req_addr", imem_req_addr, 32'h104);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_valid", 32'(imem_req_valid), 32'h0);
            chk("bp_inst_valid", 32'(inst_valid), 32'h1);
            chk("bp_inst_pc", inst_pc, 32'h100);
            chk("bp_inst_data", inst_data, ~32'h100);
            tick();
        end
        inst_ready = 1'b1;
        #1;
        chk("bp_drain0_pc", inst_pc, 32'h100);
        tick();
        chk("bp_drain1_pc", inst_pc, 32'h104);
        chk("bp_drain1_data", inst_data, ~32'h104);
        chk("bp_next_req", imem_req_addr, 32'h108);
        tick();
        chk("bp_no_dup", 32'(inst_valid), 32'h0);

        // Redirect, latency 1: in-flight response lands in the redirect cycle
        lat = 1;
        do_reset(1'b1);
        tick();
        pc_update_control = 1'b1;
        pc_update_val     = 32'h200;
        #1;
        chk("redir1_req_blocked", 32'(imem_req_valid), 32'h0);
        tick();
        pc_update_control = 1'b0;
        #1;
        chk("redir1_req_valid", 32'(imem_req_valid), 32'h1);
        chk("redir1_req_addr", imem_req_addr, 32'h200);
        chk("redir1_flushed", 32'(inst_valid), 32'h0);
        tick();
        chk("redir1_c3_empty", 32'(inst_valid), 32'h0);
        tick();
        chk("redir1_first_pc", inst_pc, 32'h200);
        chk("redir1_first_data", inst_data, ~32'h200);

        // Redirect, latency 2: stale response must be dropped
        lat = 2;
        do_reset(1'b1);
        tick();
        pc_update_control = 1'b1;
        pc_update_val     = 32'h240;
        #1;
        chk("redir2_req_blocked", 32'(imem_req_valid), 32'h0);
        tick();
        pc_update_control = 1'b0;
        #1;
        chk("redir2_req_addr", imem_req_addr, 32'h240);
        tick();
        chk("redir2_stale_dropped", 32'(inst_valid), 32'h0);
        tick();
        chk("redir2_c4_empty", 32'(inst_valid), 32'h0);
        tick();
        chk("redir2_first_pc", inst_pc, 32'h240);
        chk("redir2_first_data", inst_data, ~32'h240);

        // Ignore head, including ignore with an empty buffer
        lat = 1;
        do_reset(1'b0);
        tick();
        ignore_curr_inst = 1'b1;
        tick();
        ignore_curr_inst = 1'b0;
        #1;
        chk("ign_empty_noeffect", 32'(inst_valid), 32'h1);
        chk("ign_empty_pc", inst_pc, 32'h100);
        tick();
        chk("ign_head100", inst_pc, 32'h100);
        ignore_curr_inst = 1'b1;
        tick();
        ignore_curr_inst = 1'b0;
        #1;
        chk("ign_head104", inst_pc, 32'h104);
        chk("ign_req108", imem_req_addr, 32'h108);
        tick();
        tick();
        chk("ign_hold104", inst_pc, 32'h104);
        ignore_curr_inst = 1'b1;
        tick();
        ignore_curr_inst = 1'b0;
        #1;
        chk("ign_head108", inst_pc, 32'h108);
        tick();
        tick();
        chk("ign_hold108", inst_pc, 32'h108);
        ignore_curr_inst = 1'b1;
        tick();
        ignore_curr_inst = 1'b0;
        #1;
        chk("ign_head10c_pc", inst_pc, 32'h10C);
        chk("ign_head10c_data", inst_data, ~32'h10C);

        // PC wrap, with request back-pressure from memory
        do_reset(1'b1);
        pc_update_control = 1'b1;
        pc_update_val     = 32'hFFFF_FFFC;
        imem_req_ready    = 1'b0;
        #1;
        chk("wrap_redir_blocked", 32'(imem_req_valid), 32'h0);
        tick();
        pc_update_control = 1'b0;
        #1;
        chk("wrap_req_valid", 32'(imem_req_valid), 32'h1);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr_stable", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        tick();
        chk("wrap_next_addr", imem_req_addr, 32'h0);
        chk("wrap_next_valid", 32'(imem_req_valid), 32'h1);
        tick();
        chk("wrap_inst_pc0", inst_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_inst_pc1", inst_pc, 32'h0);
        chk("wrap_inst_data1", inst_data, 32'hFFFF_FFFF);

        // Misaligned redirect target
        do_reset(1'b1);
        chk("mis_before", 32'(misaligned_err), 32'h0);
        pc_update_control = 1'b1;
        pc_update_val     = 32'h0000_0302;
        tick();
        pc_update_control = 1'b0;
        #1;
        chk("mis_req_addr", imem_req_addr, 32'h300);
        chk("mis_flag", 32'(misaligned_err), 32'(exp_mis));
        tick();
        chk("mis_sticky", 32'(misaligned_err), 32'(exp_mis));

        do_reset(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
